// File: rtl/bcd_countdown_timer.sv
// Packed-BCD hh:mm:ss timer counting down or up, with preset validation, pause and alarm.
// Time is held in binary; every BCD output is registered from the binary next state.
module bcd_countdown_timer #(
    parameter int HORA_MAX    = 23,
    parameter int TICK_CYCLES = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hora_in,
    input  logic [7:0] minuto_in,
    input  logic [7:0] segundo_in,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic       ack,
    input  logic       modo_desc,
    output logic [7:0] hora_out,
    output logic [7:0] minuto_out,
    output logic [7:0] segundo_out,
    output logic [7:0] hora_rest,
    output logic [7:0] minuto_rest,
    output logic [7:0] segundo_rest,
    output logic       running,
    output logic       alarm,
    output logic       done,
    output logic       load_err
);
    localparam int            PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [6:0]    HMAX       = 7'(HORA_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    h_q, m_q, s_q, h_d, m_d, s_d;
    logic [6:0]    tick_h, tick_m, tick_s;
    logic [6:0]    load_h, load_m, load_s;
    logic [PW-1:0] presc_q, presc_d;
    logic          mode_q, mode_d;
    logic          alarm_d, done_d, load_err_d;
    logic          load_ok, tick_term, start_term;

    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
        return ({3'd0, b[7:4]} * 7'd10) + {3'd0, b[3:0]};
    endfunction

    function automatic logic bcd_valid(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic is_terminal(input logic down, input logic [6:0] h,
                                         input logic [6:0] m, input logic [6:0] s);
        return down ? ((h == 7'd0) && (m == 7'd0) && (s == 7'd0))
                    : ((h == HMAX) && (m == 7'd59) && (s == 7'd59));
    endfunction

    assign load_h     = bcd_to_bin(hora_in);
    assign load_m     = bcd_to_bin(minuto_in);
    assign load_s     = bcd_to_bin(segundo_in);
    assign load_ok    = bcd_valid(hora_in) && bcd_valid(minuto_in) && bcd_valid(segundo_in)
                        && (load_h <= HMAX) && (load_m <= 7'd59) && (load_s <= 7'd59);
    assign tick_term  = is_terminal(mode_q, tick_h, tick_m, tick_s);
    assign start_term = is_terminal(modo_desc, h_q, m_q, s_q);

    // Time value one tick later in the latched direction, with borrow/carry between fields.
    always_comb begin
        tick_h = h_q;
        tick_m = m_q;
        tick_s = s_q;
        if (mode_q) begin
            if (s_q != 7'd0) begin
                tick_s = s_q - 7'd1;
            end else begin
                tick_s = 7'd59;
                if (m_q != 7'd0) begin
                    tick_m = m_q - 7'd1;
                end else begin
                    tick_m = 7'd59;
                    tick_h = h_q - 7'd1;
                end
            end
        end else begin
            if (s_q != 7'd59) begin
                tick_s = s_q + 7'd1;
            end else begin
                tick_s = 7'd0;
                if (m_q != 7'd59) begin
                    tick_m = m_q + 7'd1;
                end else begin
                    tick_m = 7'd0;
                    tick_h = h_q + 7'd1;
                end
            end
        end
    end

    // Next-state logic: stop beats tick in RUN; outside RUN load beats ack and start.
    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        m_d        = m_q;
        s_d        = s_q;
        presc_d    = presc_q;
        mode_d     = mode_q;
        alarm_d    = alarm;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_PAUSE;
                    presc_d = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    h_d     = tick_h;
                    m_d     = tick_m;
                    s_d     = tick_s;
                    if (tick_term) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        alarm_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_IDLE, ST_PAUSE, ST_DONE: begin
                if (load) begin
                    if (load_ok) begin
                        h_d     = load_h;
                        m_d     = load_m;
                        s_d     = load_s;
                        presc_d = '0;
                        alarm_d = 1'b0;
                        state_d = (state_q == ST_DONE) ? ST_IDLE : state_q;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (state_q == ST_DONE) begin
                    if (ack) begin
                        state_d = ST_IDLE;
                        alarm_d = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (start && !stop) begin
                    mode_d  = modo_desc;
                    presc_d = '0;
                    if (start_term) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        alarm_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, time and registered outputs; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            h_q          <= 7'd0;
            m_q          <= 7'd0;
            s_q          <= 7'd0;
            presc_q      <= '0;
            mode_q       <= 1'b1;
            hora_out     <= 8'h00;
            minuto_out   <= 8'h00;
            segundo_out  <= 8'h00;
            hora_rest    <= bin_to_bcd(HMAX);
            minuto_rest  <= 8'h59;
            segundo_rest <= 8'h59;
            running      <= 1'b0;
            alarm        <= 1'b0;
            done         <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            m_q          <= m_d;
            s_q          <= s_d;
            presc_q      <= presc_d;
            mode_q       <= mode_d;
            hora_out     <= bin_to_bcd(h_d);
            minuto_out   <= bin_to_bcd(m_d);
            segundo_out  <= bin_to_bcd(s_d);
            hora_rest    <= bin_to_bcd(HMAX - h_d);
            minuto_rest  <= bin_to_bcd(7'd59 - m_d);
            segundo_rest <= bin_to_bcd(7'd59 - s_d);
            running      <= (state_d == ST_RUN);
            alarm        <= alarm_d;
            done         <= done_d;
            load_err     <= load_err_d;
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios plus random pulses, all checked
// against a model that keeps the time as a plain seconds count.
module tb_bcd_countdown_timer;
    localparam int HM   = 23;
    localparam int T    = 3;
    localparam int MAXT = HM * 3600 + 59 * 60 + 59;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] hora_in = 8'h00, minuto_in = 8'h00, segundo_in = 8'h00;
    logic       load = 1'b0, start = 1'b0, stop = 1'b0, ack = 1'b0, modo_desc = 1'b1;
    logic [7:0] hora_out, minuto_out, segundo_out;
    logic [7:0] hora_rest, minuto_rest, segundo_rest;
    logic       running, alarm, done, load_err;

    int n_cmp = 0;
    int n_err = 0;
    int m_st = S_IDLE, m_t = 0, m_pc = 0;
    bit m_down = 1'b1, m_alarm = 1'b0, m_done = 1'b0, m_lerr = 1'b0;
    int done_cnt;

    bcd_countdown_timer #(.HORA_MAX(HM), .TICK_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .hora_in(hora_in), .minuto_in(minuto_in), .segundo_in(segundo_in),
        .load(load), .start(start), .stop(stop), .ack(ack), .modo_desc(modo_desc),
        .hora_out(hora_out), .minuto_out(minuto_out), .segundo_out(segundo_out),
        .hora_rest(hora_rest), .minuto_rest(minuto_rest), .segundo_rest(segundo_rest),
        .running(running), .alarm(alarm), .done(done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int dec(input logic [7:0] b);
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int term_of(input bit down);
        return down ? 0 : MAXT;
    endfunction

    function automatic logic [23:0] time_bcd(input int t);
        return {bcd(t / 3600), bcd((t / 60) % 60), bcd(t % 60)};
    endfunction

    function automatic logic [23:0] rest_bcd(input int t);
        return {bcd(HM - t / 3600), bcd(59 - (t / 60) % 60), bcd(59 - t % 60)};
    endfunction

    // Reference behaviour for one rising edge, from the inputs currently applied.
    task automatic model_step();
        int nh, nm, ns;
        m_done = 1'b0;
        m_lerr = 1'b0;
        if (!reset) begin
            m_st = S_IDLE; m_t = 0; m_pc = 0; m_down = 1'b1; m_alarm = 1'b0;
        end else if (m_st == S_RUN) begin
            if (stop) begin
                m_st = S_PAUSE; m_pc = 0;
            end else begin
                m_pc++;
                if (m_pc == T) begin
                    m_pc = 0;
                    m_t = m_down ? m_t - 1 : m_t + 1;
                    if (m_t == term_of(m_down)) begin
                        m_st = S_DONE; m_done = 1'b1; m_alarm = 1'b1;
                    end
                end
            end
        end else if (load) begin
            nh = dec(hora_in); nm = dec(minuto_in); ns = dec(segundo_in);
            if (nh >= 0 && nm >= 0 && ns >= 0 && nh <= HM && nm <= 59 && ns <= 59) begin
                m_t = nh * 3600 + nm * 60 + ns;
                m_pc = 0;
                m_alarm = 1'b0;
                if (m_st == S_DONE) m_st = S_IDLE;
            end else begin
                m_lerr = 1'b1;
            end
        end else if (m_st == S_DONE) begin
            if (ack) begin
                m_st = S_IDLE; m_alarm = 1'b0;
            end
        end else if (start && !stop) begin
            m_down = modo_desc;
            m_pc = 0;
            if (m_t == term_of(m_down)) begin
                m_st = S_DONE; m_done = 1'b1; m_alarm = 1'b1;
            end else begin
                m_st = S_RUN;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_val("time", {8'h00, hora_out, minuto_out, segundo_out}, {8'h00, time_bcd(m_t)});
        check_val("rest", {8'h00, hora_rest, minuto_rest, segundo_rest}, {8'h00, rest_bcd(m_t)});
        check_val("flags", {28'd0, running, alarm, done, load_err},
                  {28'd0, m_st == S_RUN, m_alarm, m_done, m_lerr});
        load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
    endtask

    task automatic set_preset(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        hora_in = h; minuto_in = m; segundo_in = s;
    endtask

    task automatic random_preset();
        int k;
        k = int'($urandom_range(0, 4));
        case (k)
            0: set_preset(8'h00, 8'h00, bcd(int'($urandom_range(0, 6))));
            1: set_preset(bcd(HM), 8'h59, bcd(int'($urandom_range(53, 59))));
            2: set_preset(bcd(int'($urandom_range(0, HM))), bcd(int'($urandom_range(0, 59))),
                          bcd(int'($urandom_range(0, 59))));
            3: set_preset(bcd(int'($urandom_range(24, 29))), 8'h00, 8'h10);
            default: set_preset(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                                8'($urandom_range(0, 255)));
        endcase
    endtask

    initial begin
        int r;
        reset = 1'b0;
        step(); step();
        check_val("reset_time", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0000_0000);
        check_val("reset_rest", {8'h00, hora_rest, minuto_rest, segundo_rest}, 32'h0023_5959);
        check_val("reset_flags", {28'd0, running, alarm, done, load_err}, 32'd0);
        reset = 1'b1;

        // Count down from 00:01:05 to zero.
        set_preset(8'h00, 8'h01, 8'h05); load = 1'b1; step();
        modo_desc = 1'b1; start = 1'b1; step();
        repeat (5 * T) step();
        check_val("down_5ticks", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0000_0100);
        done_cnt = 0;
        for (int i = 0; i < 60 * T + 3; i++) begin
            step();
            done_cnt += int'(done);
        end
        check_val("down_end", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0000_0000);
        check_val("done_once", 32'(done_cnt), 32'd1);
        check_val("alarm_on", {31'd0, alarm}, 32'd1);
        check_val("rest_at_zero", {8'h00, hora_rest, minuto_rest, segundo_rest}, 32'h0023_5959);
        ack = 1'b1; step();
        check_val("ack_flags", {28'd0, running, alarm, done, load_err}, 32'd0);
        check_val("ack_held", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0000_0000);

        // Count up with minute carry, then up to the terminal value.
        set_preset(8'h00, 8'h00, 8'h59); load = 1'b1; step();
        modo_desc = 1'b0; start = 1'b1; step();
        repeat (T) step();
        check_val("up_carry", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0000_0100);
        stop = 1'b1; step();
        set_preset(8'h23, 8'h59, 8'h58); load = 1'b1; step();
        modo_desc = 1'b0; start = 1'b1; step();
        repeat (T) step();
        check_val("up_term", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0023_5959);
        check_val("up_done", {28'd0, running, alarm, done, load_err}, 32'b0110);
        ack = 1'b1; step();

        // Rejected presets leave the value alone.
        set_preset(8'h24, 8'h00, 8'h00); load = 1'b1; step();
        check_val("bad_hour", {28'd0, running, alarm, done, load_err}, 32'b0001);
        check_val("bad_hour_val", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0023_5959);
        set_preset(8'h00, 8'h5A, 8'h00); load = 1'b1; step();
        check_val("bad_min", {28'd0, running, alarm, done, load_err}, 32'b0001);
        check_val("bad_min_val", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0023_5959);

        // Pause and resume.
        set_preset(8'h00, 8'h00, 8'h10); load = 1'b1; step();
        modo_desc = 1'b1; start = 1'b1; step();
        repeat (3 * T) step();
        check_val("pre_stop", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0000_0007);
        stop = 1'b1; step();
        repeat (5 * T) step();
        check_val("paused_val", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0000_0007);
        check_val("paused_flags", {28'd0, running, alarm, done, load_err}, 32'd0);
        start = 1'b1; step();
        repeat (T - 1) step();
        check_val("resume_early", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0000_0007);
        step();
        check_val("resume_tick", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0000_0006);
        stop = 1'b1; step();
        start = 1'b1; stop = 1'b1; step();
        check_val("start_stop", {31'd0, running}, 32'd0);

        // Reset mid-run, then load+start in IDLE.
        set_preset(8'h12, 8'h34, 8'h56); load = 1'b1; step();
        start = 1'b1; step();
        step(); step();
        reset = 1'b0; start = 1'b1; step();
        check_val("rst_run_time", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0000_0000);
        check_val("rst_run_flags", {28'd0, running, alarm, done, load_err}, 32'd0);
        reset = 1'b1;
        set_preset(8'h00, 8'h00, 8'h05); load = 1'b1; start = 1'b1; step();
        check_val("load_start_val", {8'h00, hora_out, minuto_out, segundo_out}, 32'h0000_0005);
        step();
        check_val("load_start_idle", {31'd0, running}, 32'd0);

        // Random pulses with presets clustered near the terminal values.
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 199));
            random_preset();
            modo_desc = 1'($urandom_range(0, 1));
            load  = (r < 8);
            start = (r >= 8 && r < 24);
            stop  = (r >= 24 && r < 30) || (r == 8);
            ack   = (r >= 30 && r < 40);
            reset = (r != 199);
            step();
        end
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
